perceptron_train_ctrl: RTL and testbench

- Control FSM that sequences the two-input perceptron training datapath.
- Per sample: fetches it from an external sample ROM, loads the datapath input registers, evaluates Y against t, and applies the w1/w2/b update when they differ.
- Repeats epochs until one epoch needs no update or the epoch limit is reached, then asserts Finish_Flag so the datapath publishes W1out/W2out/bout.
- Sits between the top-level start/done handshake and the datapath enables/selects.

---
 rtl/perceptron_train_pkg.sv | 21 ++
 rtl/perceptron_sample_seq.sv | 47 ++++
 rtl/perceptron_train_ctrl.sv | 163 ++++++++++++++++
 tb/tb_perceptron_train_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/perceptron_train_pkg.sv
// rtl/perceptron_train_pkg.sv - state encoding and datapath select codes for the perceptron training controller
package perceptron_train_pkg;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    LOAD,
    EVAL,
    UPD_W1,
    UPD_W2,
    UPD_B,
    NEXT,
    CHECK,
    FINISH
  } state_t;

  localparam logic [1:0] SEL_W1 = 2'b00;
  localparam logic [1:0] SEL_W2 = 2'b01;
  localparam logic [1:0] SEL_B  = 2'b10;

endpackage

// File: rtl/perceptron_sample_seq.sv
// rtl/perceptron_sample_seq.sv - sample address counter with wrap flag and saturating epoch counter with limit compare
module perceptron_sample_seq
  import perceptron_train_pkg::*;
#(
  parameter int N_SAMPLES  = 4,
  parameter int ADDR_W     = 8,
  parameter int MAX_EPOCHS = 16,
  parameter int EPOCH_W    = 8
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               i_addr_clr,
  input  logic               i_addr_step,
  input  logic               i_epoch_clr,
  input  logic               i_epoch_inc,
  output logic [ADDR_W-1:0]  o_mem_addr,
  output logic               o_addr_last,
  output logic [EPOCH_W-1:0] o_epoch_cnt,
  output logic               o_epoch_limit
);

  logic [ADDR_W-1:0]  r_addr;
  logic [EPOCH_W-1:0] r_epoch;

  assign o_mem_addr    = r_addr;
  assign o_epoch_cnt   = r_epoch;
  assign o_addr_last   = (r_addr == ADDR_W'(N_SAMPLES - 1));
  // True when the epoch now being closed is the last one allowed
  assign o_epoch_limit = ((32'(r_epoch) + 32'd1) == 32'(MAX_EPOCHS));

  always_ff @(posedge Clk) begin
    if (Rst || i_addr_clr) begin
      r_addr <= '0;
    end else if (i_addr_step) begin
      r_addr <= o_addr_last ? '0 : r_addr + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst || i_epoch_clr) begin
      r_epoch <= '0;
    end else if (i_epoch_inc && (r_epoch != '1)) begin
      r_epoch <= r_epoch + 1'b1;
    end
  end

endmodule

// File: rtl/perceptron_train_ctrl.sv
// rtl/perceptron_train_ctrl.sv - control FSM sequencing fetch/evaluate/update epochs of the perceptron datapath
// Optional per-epoch mismatch counter on o_err_cnt is built only when PERCEPTRON_ERR_COUNT_EN is defined.
module perceptron_train_ctrl
  import perceptron_train_pkg::*;
#(
  parameter int N_SAMPLES  = 4,
  parameter int ADDR_W     = 8,
  parameter int MAX_EPOCHS = 16,
  parameter int EPOCH_W    = 8
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               i_start,
  input  logic               i_ttoy_flag,
  output logic [ADDR_W-1:0]  o_mem_addr,
  output logic               o_mem_rd,
  output logic               o_enx1,
  output logic               o_enx2,
  output logic               o_ent,
  output logic               o_enw1,
  output logic               o_enw2,
  output logic               o_enb,
  output logic [1:0]         o_sel,
  output logic [1:0]         o_dsel,
  output logic               o_finish_flag,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_converged,
  output logic [EPOCH_W-1:0] o_epoch_cnt,
  output logic [ADDR_W-1:0]  o_err_cnt
);

  state_t r_state, w_next;
  logic   r_upd_seen, r_done, r_converged;
  logic   w_run_start, w_addr_step, w_epoch_inc, w_addr_last, w_epoch_limit;
  logic   w_mismatch, w_epoch_again, w_to_finish;

  perceptron_sample_seq #(
    .N_SAMPLES (N_SAMPLES),
    .ADDR_W    (ADDR_W),
    .MAX_EPOCHS(MAX_EPOCHS),
    .EPOCH_W   (EPOCH_W)
  ) u_seq (
    .Clk          (Clk),
    .Rst          (Rst),
    .i_addr_clr   (w_run_start),
    .i_addr_step  (w_addr_step),
    .i_epoch_clr  (w_run_start),
    .i_epoch_inc  (w_epoch_inc),
    .o_mem_addr   (o_mem_addr),
    .o_addr_last  (w_addr_last),
    .o_epoch_cnt  (o_epoch_cnt),
    .o_epoch_limit(w_epoch_limit)
  );

  always_ff @(posedge Clk) begin
    if (Rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_run_start = 1'b0;
    w_addr_step = 1'b0;
    w_epoch_inc = 1'b0;
    o_mem_rd    = 1'b0;
    o_enx1      = 1'b0;
    o_enx2      = 1'b0;
    o_ent       = 1'b0;
    o_enw1      = 1'b0;
    o_enw2      = 1'b0;
    o_enb       = 1'b0;
    o_sel       = SEL_W1;
    o_dsel      = SEL_W1;
    case (r_state)
      IDLE, FINISH: begin
        if (i_start) begin
          w_run_start = 1'b1;
          w_next      = FETCH;
        end
      end
      FETCH: begin
        o_mem_rd = 1'b1;
        w_next   = LOAD;
      end
      LOAD: begin
        o_enx1 = 1'b1;
        o_enx2 = 1'b1;
        o_ent  = 1'b1;
        w_next = EVAL;
      end
      EVAL:   w_next = i_ttoy_flag ? NEXT : UPD_W1;
      UPD_W1: begin
        o_sel  = SEL_W1;
        o_dsel = SEL_W1;
        o_enw1 = 1'b1;
        w_next = UPD_W2;
      end
      UPD_W2: begin
        o_sel  = SEL_W2;
        o_dsel = SEL_W2;
        o_enw2 = 1'b1;
        w_next = UPD_B;
      end
      UPD_B: begin
        o_sel  = SEL_B;
        o_dsel = SEL_B;
        o_enb  = 1'b1;
        w_next = NEXT;
      end
      NEXT: begin
        w_addr_step = 1'b1;
        w_next      = w_addr_last ? CHECK : FETCH;
      end
      CHECK: begin
        w_epoch_inc = 1'b1;
        w_next      = (!r_upd_seen || w_epoch_limit) ? FINISH : FETCH;
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_mismatch    = (r_state == EVAL) && !i_ttoy_flag;
  assign w_epoch_again = (r_state == CHECK) && (w_next == FETCH);
  assign w_to_finish   = (r_state == CHECK) && (w_next == FINISH);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_upd_seen  <= 1'b0;
      r_converged <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= w_to_finish;
      if (w_run_start || w_epoch_again) r_upd_seen <= 1'b0;
      else if (w_mismatch)              r_upd_seen <= 1'b1;
      if (w_run_start)      r_converged <= 1'b0;
      else if (w_to_finish) r_converged <= !r_upd_seen;
    end
  end

  assign o_finish_flag = (r_state == FINISH);
  assign o_busy        = (r_state != IDLE) && (r_state != FINISH);
  assign o_done        = r_done;
  assign o_converged   = r_converged;

`ifdef PERCEPTRON_ERR_COUNT_EN
  logic [ADDR_W-1:0] r_err_cnt;

  // Cleared only when another epoch follows, so FINISH keeps the final epoch's count
  always_ff @(posedge Clk) begin
    if (Rst || w_run_start || w_epoch_again) begin
      r_err_cnt <= '0;
    end else if (w_mismatch && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign o_err_cnt = r_err_cnt;
`else
  assign o_err_cnt = '0;
`endif

endmodule

// File: tb/tb_perceptron_train_ctrl.sv
// tb/tb_perceptron_train_ctrl.sv - scoreboard bench for perceptron_train_ctrl (honours PERCEPTRON_ERR_COUNT_EN)
module tb_perceptron_train_ctrl;

  localparam int NS = 4;
  localparam int AW = 8;
  localparam int ME = 3;
  localparam int EW = 8;

  logic          Clk = 1'b0;
  logic          Rst = 1'b1;
  logic          start = 1'b0;
  logic          ttoy;
  logic [AW-1:0] mem_addr;
  logic          mem_rd, enx1, enx2, ent, enw1, enw2, enb;
  logic [1:0]    sel, dsel;
  logic          finish_flag, busy, done, converged;
  logic [EW-1:0] epoch_cnt;
  logic [AW-1:0] err_cnt;

  perceptron_train_ctrl #(
    .N_SAMPLES(NS), .ADDR_W(AW), .MAX_EPOCHS(ME), .EPOCH_W(EW)
  ) dut (
    .Clk(Clk), .Rst(Rst), .i_start(start), .i_ttoy_flag(ttoy),
    .o_mem_addr(mem_addr), .o_mem_rd(mem_rd),
    .o_enx1(enx1), .o_enx2(enx2), .o_ent(ent),
    .o_enw1(enw1), .o_enw2(enw2), .o_enb(enb),
    .o_sel(sel), .o_dsel(dsel), .o_finish_flag(finish_flag),
    .o_busy(busy), .o_done(done), .o_converged(converged),
    .o_epoch_cnt(epoch_cnt), .o_err_cnt(err_cnt)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct { int addr; int err; } addr_exp_t;
  typedef struct { int conv; int epoch; int lat; int err; } done_exp_t;

  addr_exp_t q_addr[$];
  int        q_upd[$];
  done_exp_t q_done[$];

  int          n_pass = 0;
  int          n_total = 0;
  int          rd_cnt = 0;
  int          base = 0;
  int          start_edge = 0;
  int          done_cnt = 0;
  logic [63:0] mis_mask = '0;

  addr_exp_t m_ea;
  done_exp_t m_ed;
  int        m_code;
  logic [2:0] m_w;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int ev(input int v);
`ifdef PERCEPTRON_ERR_COUNT_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  // Datapath model: Y==t unless the current fetch of this run is marked as a mismatch
  always_comb begin
    ttoy = 1'b1;
    if ((rd_cnt - base >= 1) && (rd_cnt - base <= 64)) ttoy = !mis_mask[rd_cnt - base - 1];
  end

  always @(negedge Clk) begin
    if (mem_rd) begin
      rd_cnt++;
      check("fetch_expected", int'(q_addr.size() != 0), 1);
      if (q_addr.size() != 0) begin
        m_ea = q_addr.pop_front();
        check("mem_addr", mem_addr, m_ea.addr);
        check("err_at_fetch", err_cnt, m_ea.err);
      end
    end
    m_w = {enb, enw2, enw1};
    if (m_w != 3'b000) begin
      check("upd_expected", int'(q_upd.size() != 0), 1);
      if (q_upd.size() != 0) begin
        m_code = q_upd.pop_front();
        check("upd_onehot", m_w, 1 << m_code);
        check("sel", sel, m_code);
        check("dsel", dsel, m_code);
      end
    end else begin
      check("sel_dsel_idle", {sel, dsel}, 0);
    end
    if (done) begin
      done_cnt++;
      check("done_expected", int'(q_done.size() != 0), 1);
      if (q_done.size() != 0) begin
        m_ed = q_done.pop_front();
        check("converged", converged, m_ed.conv);
        check("epoch_cnt", epoch_cnt, m_ed.epoch);
        check("done_latency", cyc - start_edge, m_ed.lat);
        check("err_at_done", err_cnt, m_ed.err);
        check("finish_flag_at_done", finish_flag, 1);
        check("busy_at_done", busy, 0);
      end
    end
  end

  task automatic push_run(input logic [63:0] mask, input int n_fetch);
    int errs;
    errs = 0;
    for (int k = 0; k < n_fetch; k++) begin
      if (k % NS == 0) errs = 0;
      q_addr.push_back('{k % NS, ev(errs)});
      if (mask[k]) begin
        errs++;
        for (int c = 0; c < 3; c++) q_upd.push_back(c);
      end
    end
  endtask

  task automatic run_start(input logic [63:0] mask);
    @(negedge Clk);
    mis_mask = mask;
    base     = rd_cnt;
    start    = 1'b1;
    @(negedge Clk);
    start      = 1'b0;
    start_edge = cyc;
  endtask

  task automatic wait_done(input int budget);
    int target;
    int n;
    target = done_cnt + 1;
    n = 0;
    while ((done_cnt < target) && (n < budget)) begin
      @(posedge Clk);
      n++;
    end
    check("done_within_budget", int'(done_cnt >= target), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;
    repeat (3) @(negedge Clk);
    check("reset_outputs", {mem_addr, mem_rd, enx1, enx2, ent, enw1, enw2, enb, sel, dsel,
                            finish_flag, busy, done, converged, epoch_cnt, err_cnt}, 0);
    Rst = 1'b0;

    // All samples match: one clean epoch
    push_run(64'h0, 4);
    q_done.push_back('{1, 1, 17, 0});
    run_start(64'h0);
    wait_done(100);

    // Sample 2 of epoch 1 mismatches, epoch 2 clean (started from FINISH)
    push_run(64'h4, 8);
    q_done.push_back('{1, 2, 37, 0});
    run_start(64'h4);
    wait_done(200);

    // Every sample mismatches: epoch limit forces finish
    push_run('1, 12);
    q_done.push_back('{0, 3, 87, ev(4)});
    run_start('1);
    wait_done(300);
    repeat (5) begin
      @(negedge Clk);
      check("finish_flag_held", finish_flag, 1);
      check("busy_in_finish", busy, 0);
      check("done_single_pulse", done, 0);
    end

    // Reset while the w2 update is in flight
    q_addr.push_back('{0, 0});
    q_upd.push_back(0);
    q_upd.push_back(1);
    run_start('1);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (enw2) begin
        found = 1'b1;
        break;
      end
      @(negedge Clk);
    end
    check("reached_upd_w2", found, 1);
    Rst = 1'b1;
    @(negedge Clk);
    check("abort_outputs", {mem_addr, mem_rd, enx1, enx2, ent, enw1, enw2, enb, sel, dsel,
                            finish_flag, busy, done, converged, epoch_cnt, err_cnt}, 0);
    Rst = 1'b0;
    check("abort_addr_q_empty", q_addr.size(), 0);
    check("abort_upd_q_empty", q_upd.size(), 0);

    // Start pulsed during EVAL is ignored
    push_run(64'h0, 4);
    q_done.push_back('{1, 1, 17, 0});
    run_start(64'h0);
    @(negedge Clk);
    @(negedge Clk);
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    check("epoch_after_ignored_start", epoch_cnt, 0);
    wait_done(100);

    // Restart from FINISH with two mismatches early in epoch 1
    push_run(64'h3, 8);
    q_done.push_back('{1, 2, 40, 0});
    run_start(64'h3);
    check("restart_finish_drop", finish_flag, 0);
    check("restart_busy", busy, 1);
    check("restart_addr", mem_addr, 0);
    wait_done(200);

    repeat (3) @(negedge Clk);
    check("final_addr_q_empty", q_addr.size(), 0);
    check("final_upd_q_empty", q_upd.size(), 0);
    check("final_done_q_empty", q_done.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
